// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: FIFO read-side consumer that absorbs the one-cycle read latency and streams words through an FWFT skid buffer
module fifo_drain_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      rd_count,
  output logic                  underflow_err
);
  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);
  localparam logic [1:0] LAST  = 2'(BUF_DEPTH - 1);
  logic [FIFO_WIDTH-1:0] r_buf [4];
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [2:0]            r_cnt;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_rd_count;
  logic                  r_uerr;
  logic                  w_push;
  logic                  w_pop;
  assign w_push        = r_inflight;
  assign w_pop         = m_valid & m_ready;
  assign m_valid       = r_cnt != 3'd0;
  assign m_data        = m_valid ? r_buf[r_head] : '0;
  assign rd_count      = r_rd_count;
  assign underflow_err = r_uerr;
  // a read is only issued when the buffer can hold it plus whatever is still in flight
  assign fifo_rd_en    = rst_n & enable & ~fifo_empty & ((r_cnt + {2'b00, r_inflight}) < DEPTH);
  // buffer storage needs no reset: entries are only visible once counted as occupied
  always_ff @(posedge clk)
    if (w_push) r_buf[r_tail] <= fifo_data_out;
  // pointer, occupancy, in-flight, word counter and sticky underflow bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_rd_count <= '0;
      r_uerr     <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_cnt      <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      if (w_push) r_tail <= (r_tail == LAST) ? 2'd0 : r_tail + 2'd1;
      if (w_push) r_rd_count <= r_rd_count + 1'b1;
      if (w_pop) r_head <= (r_head == LAST) ? 2'd0 : r_head + 2'd1;
      if (fifo_underflow) r_uerr <= 1'b1;
    end
  // occupancy can never exceed the buffer because reads reserve their slot at issue
  always_ff @(posedge clk)
    if (rst_n) assert (r_cnt <= DEPTH);
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: table vectors, directed corner sequences and a randomized scoreboard run for fifo_drain_ctrl
module tb_fifo_drain_ctrl;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_rd_en;
  logic [15:0]   fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [15:0]   m_data;
  logic [CW-1:0] rd_count;
  logic          underflow_err;
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] mem [1024];
  int wp = 0;
  int rp = 0;
  logic [15:0] exp_q [$];
  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [15:0] data;
    logic [3:0]  cnt;
  } vec_t;
  vec_t tbl [14];

  fifo_drain_ctrl #(.FIFO_WIDTH(16), .BUF_DEPTH(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // FIFO model with registered read data: a word popped at a posedge appears after it
  assign fifo_empty = (wp == rp);
  always @(posedge clk)
    if (fifo_rd_en && wp != rp) begin
      fifo_data_out <= mem[rp % 1024];
      rp <= rp + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wp % 1024] = w;
    wp++;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    repeat (2) @(negedge clk);
    wp = rp;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int issued;
    int delivered;
    int n_push;
    logic pv;
    logic [15:0] pd;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd3};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 4'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 4'd3};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 4'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 4'd5};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 4'd6};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 4'd7};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 4'd8};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd8};
    // backpressure then release, cycle by cycle from the table
    do_reset();
    #1;
    chk("reset_valid", m_valid, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_count", rd_count, 0);
    chk("reset_uerr", underflow_err, 0);
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      enable = tbl[k].en;
      m_ready = tbl[k].rdy;
      #1;
      chk($sformatf("tbl%0d_rd_en", k), fifo_rd_en, tbl[k].rd);
      chk($sformatf("tbl%0d_valid", k), m_valid, tbl[k].vld);
      if (tbl[k].vld) chk($sformatf("tbl%0d_data", k), m_data, tbl[k].data);
      chk($sformatf("tbl%0d_count", k), rd_count, tbl[k].cnt);
    end
    // streaming 8 words at full rate, then the empty boundary
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      enable = 1'b1;
      m_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d_rd_en", k), fifo_rd_en, k < 8);
      chk($sformatf("stream%0d_valid", k), m_valid, k >= 2 && k < 10);
      if (k >= 2 && k < 10) chk($sformatf("stream%0d_data", k), m_data, k - 1);
      if (fifo_empty) chk($sformatf("stream%0d_rd_en_empty", k), fifo_rd_en, 0);
    end
    chk("stream_count", rd_count, 8);
    chk("stream_uerr", underflow_err, 0);
    // reset mid-stream drops the buffered and in-flight words
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    @(negedge clk);
    enable = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("midrst_first_rd", fifo_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrst_pre_valid", m_valid, 1);
    chk("midrst_pre_data", m_data, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_count", rd_count, 0);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_drop_valid", m_valid, 0);
    chk("midrst_drop_count", rd_count, 0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    chk("midrst_resume_rd", fifo_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrst_resume_valid", m_valid, 1);
    chk("midrst_resume_data", m_data, 3);
    // enable drop right after a read is issued
    do_reset();
    @(negedge clk);
    push_word(16'h0055);
    push_word(16'h0066);
    enable = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("endrop_rd", fifo_rd_en, 1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("endrop_rd_off", fifo_rd_en, 0);
    chk("endrop_valid_n1", m_valid, 0);
    @(negedge clk);
    #1;
    chk("endrop_valid_n2", m_valid, 1);
    chk("endrop_data_n2", m_data, 16'h0055);
    chk("endrop_rd_n2", fifo_rd_en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("endrop_idle%0d_rd", k), fifo_rd_en, 0);
      chk($sformatf("endrop_idle%0d_valid", k), m_valid, 0);
    end
    @(negedge clk);
    enable = 1'b1;
    #1;
    chk("endrop_reenable_rd", fifo_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("endrop_second_valid", m_valid, 1);
    chk("endrop_second_data", m_data, 16'h0066);
    // sticky underflow error
    do_reset();
    #1;
    chk("uerr_before", underflow_err, 0);
    @(negedge clk);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    #1;
    chk("uerr_set", underflow_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("uerr_sticky", underflow_err, 1);
    do_reset();
    #1;
    chk("uerr_cleared", underflow_err, 0);
    // counter wrap: 17 reads into a 4-bit counter
    for (int i = 0; i < 17; i++) push_word(16'(16'h0100 + i));
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      enable = 1'b1;
      m_ready = 1'b1;
      #1;
      if (m_valid) chk($sformatf("wrap%0d_data", k), m_data, exp_q.size() != 0 ? exp_q.pop_front() : 16'hdead);
    end
    chk("wrap_all_delivered", exp_q.size(), 0);
    chk("wrap_count", rd_count, 17 % (1 << CW));
    // randomized traffic against an in-order, no-loss, bounded-occupancy model
    do_reset();
    issued = 0;
    delivered = 0;
    n_push = 0;
    pv = 1'b0;
    pd = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (c < 600 && $urandom_range(0, 1) == 1 && (wp - rp) < 12) begin
        push_word(16'($urandom));
        n_push++;
      end
      enable = (c >= 600) || ($urandom_range(0, 3) != 0);
      m_ready = (c >= 600) || ($urandom_range(0, 2) != 0);
      #1;
      if (fifo_empty) chk("rnd_rd_en_empty", fifo_rd_en, 0);
      chk("rnd_occupancy", (issued - delivered) <= 3, 1);
      if (pv) begin
        chk("rnd_hold_valid", m_valid, 1);
        chk("rnd_hold_data", m_data, pd);
      end
      if (m_valid && m_ready) begin
        chk("rnd_data", m_data, exp_q.size() != 0 ? exp_q.pop_front() : 16'hdead);
        delivered++;
      end
      if (fifo_rd_en) issued++;
      pv = m_valid && !m_ready;
      pd = m_data;
    end
    chk("rnd_all_delivered", exp_q.size(), 0);
    chk("rnd_count", rd_count, n_push % (1 << CW));
    chk("rnd_uerr", underflow_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
